serial_alu_w: RTL and testbench

Parametrised bit-serial ALU. It computes one result bit per clock over a WIDTH-bit operand pair with a start/busy/done handshake, and reports zero, carry/borrow, sign and signed-overflow flags. It is the next generation of the team's fixed 4-bit serial ALU and sits between the datapath register file and the flag register. Operands are captured at start, and results and flags update atomically at completion.

---
 rtl/serial_alu_pkg.sv | 38 +++
 rtl/serial_alu_bit_slice.sv | 40 ++++
 rtl/serial_alu_w.sv | 149 ++++++++++++++
 tb/tb_serial_alu_w.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
// serial_alu_pkg -- opcodes, FSM encoding and carry-seed helper for serial_alu_w
// Revision 1.0
// ============================================================================
package serial_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_ADC  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // SUB forms a + ~b + 1, so its "+1" enters as the initial carry.
  function automatic logic carry_seed(input logic [2:0] op, input logic cf_in);
    logic seed;
    case (op)
      OP_SUB:  seed = 1'b1;
      OP_ADC:  seed = cf_in;
      default: seed = 1'b0;
    endcase
    return seed;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_bit_slice.sv
`default_nettype none
// ============================================================================
// serial_alu_bit_slice -- one-bit combinational ALU cell with SUB operand inversion
// Revision 1.0
// ============================================================================
module serial_alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       ci,
  input  logic [2:0] op,
  output logic       ri,
  output logic       co
);

  logic bx;

  always_comb begin
    bx = (op == OP_SUB) ? ~bi : bi;
    ri = 1'b0;
    co = 1'b0;
    case (op)
      OP_XOR:  ri = ai ^ bi;
      OP_XNOR: ri = ~(ai ^ bi);
      OP_AND:  ri = ai & bi;
      OP_OR:   ri = ai | bi;
      OP_ADD, OP_SUB, OP_ADC: begin
        ri = ai ^ bx ^ ci;
        co = (ai & bx) | (ai & ci) | (bx & ci);
      end
      default: begin
        ri = 1'b0;
        co = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_w.sv
`default_nettype none
// ============================================================================
// serial_alu_w -- parametrised bit-serial ALU, one result bit per clock, atomic flags
// Revision 1.0
// ============================================================================
module serial_alu_w
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zf,
  output logic             cf,
  output logic             sf,
  output logic             vf,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;
  logic             sf_q, sf_d;
  logic             vf_q, vf_d;
  logic             done_q, done_d;

  logic             slice_r;
  logic             slice_co;
  logic [WIDTH-1:0] result_w;

  serial_alu_bit_slice u_slice (
    .ai (a_sr_q[0]),
    .bi (b_sr_q[0]),
    .ci (carry_q),
    .op (op_q),
    .ri (slice_r),
    .co (slice_co)
  );

  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign result_w = {slice_r, r_sr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    op_d    = op_q;
    carry_d = carry_q;
    c_d     = c_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    vf_d    = vf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (opcode != OP_NOP)) begin
          state_d = ST_RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          r_sr_d  = '0;
          op_d    = opcode;
          carry_d = carry_seed(opcode, cf_q);
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        r_sr_d  = result_w;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          c_d     = result_w;
          zf_d    = (result_w == '0);
          sf_d    = slice_r;
          // The MSB slice sees carry_q as carry-in, so overflow is carry-in vs carry-out.
          cf_d    = is_arith(op_q) ? ((op_q == OP_SUB) ? ~slice_co : slice_co) : 1'b0;
          vf_d    = is_arith(op_q) ? (carry_q ^ slice_co) : 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      op_q    <= OP_NOP;
      carry_q <= 1'b0;
      c_q     <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      sf_q    <= 1'b0;
      vf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      vf_q    <= vf_d;
      done_q  <= done_d;
    end
  end

  assign c    = c_q;
  assign zf   = zf_q;
  assign cf   = cf_q;
  assign sf   = sf_q;
  assign vf   = vf_q;
  assign done = done_q;
  assign busy = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_w.sv
`default_nettype none
// ============================================================================
// tb_serial_alu_w -- randomized self-checking bench for serial_alu_w (WIDTH 8 and 4)
// Revision 1.0
// ============================================================================
module tb_serial_alu_w;
  import serial_alu_pkg::*;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, start4;
  logic [2:0]    opcode, opcode4;
  logic [W-1:0]  a, b, c;
  logic [W4-1:0] a4, b4, c4;
  logic          zf, cf, sf, vf, busy, done;
  logic          zf4, cf4, sf4, vf4, busy4, done4;

  int   n_checks = 0;
  int   n_errors = 0;
  logic model_cf;
  logic model_cf4;

  serial_alu_w #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
    .c(c), .zf(zf), .cf(cf), .sf(sf), .vf(vf), .busy(busy), .done(done)
  );

  serial_alu_w #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .opcode(opcode4), .a(a4), .b(b4),
    .c(c4), .zf(zf4), .cf(cf4), .sf(sf4), .vf(vf4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow judged on the true signed result.
  function automatic void ref_alu(input logic [2:0] op, input longint ua, input longint ub,
                                  input int w, input logic cin, output logic [31:0] r,
                                  output logic ez, output logic ec, output logic es,
                                  output logic ev);
    longint m, half, sa, sb, full, sres;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    ec   = 1'b0;
    ev   = 1'b0;
    sres = 0;
    case (op)
      OP_XOR:  full = ua ^ ub;
      OP_XNOR: full = ~(ua ^ ub);
      OP_AND:  full = ua & ub;
      OP_OR:   full = ua | ub;
      OP_ADD: begin
        full = ua + ub;
        ec   = (full > m);
        sres = sa + sb;
        ev   = (sres >= half) || (sres < -half);
      end
      OP_ADC: begin
        full = ua + ub + longint'(cin);
        ec   = (full > m);
        sres = sa + sb + longint'(cin);
        ev   = (sres >= half) || (sres < -half);
      end
      OP_SUB: begin
        full = ua - ub;
        ec   = (ua < ub);
        sres = sa - sb;
        ev   = (sres >= half) || (sres < -half);
      end
      default: full = 0;
    endcase
    r  = 32'(full & m);
    ez = (r == 32'd0);
    es = ((full & m) >> (w - 1)) != 0;
  endfunction

  // Issues one op on the 8-bit DUT; disturbs start/a/b/opcode mid-run.
  task automatic run8(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                      input string tag);
    logic [31:0] er;
    logic        ez, ec, es, ev;
    ref_alu(op, longint'(va), longint'(vb), W, model_cf, er, ez, ec, es, ev);
    start  = 1'b1;
    opcode = op;
    a      = va;
    b      = vb;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " done_after_start"}, done, 0);
    for (int i = 1; i <= W; i++) begin
      if (i >= 2 && i <= 4) begin
        start  = 1'b1;
        opcode = 3'($urandom_range(1, 7));
        a      = 8'($urandom);
        b      = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (i < W) begin
        if (done !== 1'b0 || busy !== 1'b1)
          check({tag, " early_done_or_idle"}, {busy, done}, 2'b10);
      end
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " c"}, c, er);
    check({tag, " zf"}, zf, ez);
    check({tag, " cf"}, cf, ec);
    check({tag, " sf"}, sf, es);
    check({tag, " vf"}, vf, ev);
    model_cf = ec;
  endtask

  task automatic run4(input logic [2:0] op, input logic [3:0] va, input logic [3:0] vb,
                      input string tag);
    logic [31:0] er;
    logic        ez, ec, es, ev;
    ref_alu(op, longint'(va), longint'(vb), W4, model_cf4, er, ez, ec, es, ev);
    start4  = 1'b1;
    opcode4 = op;
    a4      = va;
    b4      = vb;
    @(posedge clk); #1;
    start4 = 1'b0;
    check({tag, " busy_after_start"}, busy4, 1);
    for (int i = 1; i <= W4; i++) begin
      @(posedge clk); #1;
      if (i < W4 && done4 !== 1'b0)
        check({tag, " early_done"}, done4, 0);
    end
    check({tag, " done"}, done4, 1);
    check({tag, " busy_end"}, busy4, 0);
    check({tag, " c"}, c4, er);
    check({tag, " zf"}, zf4, ez);
    check({tag, " cf"}, cf4, ec);
    check({tag, " sf"}, sf4, es);
    check({tag, " vf"}, vf4, ev);
    model_cf4 = ec;
  endtask

  task automatic idle8(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0)
        check("idle_quiet", {busy, done}, 2'b00);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    start4    = 1'b0;
    opcode    = OP_NOP;
    opcode4   = OP_NOP;
    a         = '0;
    b         = '0;
    a4        = '0;
    b4        = '0;
    model_cf  = 1'b0;
    model_cf4 = 1'b0;

    #2;
    check("reset_outputs", {c, zf, cf, sf, vf, busy, done}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", {c, zf, cf, sf, vf, busy, done}, '0);

    // NOP with start held must not start anything
    start  = 1'b1;
    opcode = OP_NOP;
    a      = 8'h55;
    b      = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("nop_busy", busy, 0);
      check("nop_done", done, 0);
    end
    start = 1'b0;
    check("nop_c", c, 0);

    run8(OP_ADD, 8'h7F, 8'h01, "add_7f_01");
    idle8(2);
    run8(OP_SUB, 8'h05, 8'h05, "sub_05_05");
    run8(OP_SUB, 8'h03, 8'h05, "sub_03_05_b2b");
    idle8(1);
    run8(OP_ADD, 8'hFF, 8'h01, "add_ff_01");
    run8(OP_ADC, 8'h00, 8'h00, "adc_00_00");
    idle8(1);
    run8(OP_XOR, 8'hA5, 8'hFF, "xor_a5_ff");
    idle8(1);
    run8(OP_OR, 8'hF0, 8'h0F, "or_f0_0f");

    // Abort at RUN cycle 3
    start  = 1'b1;
    opcode = OP_ADD;
    a      = 8'h81;
    b      = 8'h81;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs", {c, zf, cf, sf, vf, busy, done}, '0);
    model_cf  = 1'b0;
    model_cf4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0)
        check("abort_no_done", {busy, done}, 2'b00);
    end
    check("abort_c_held", c, 0);
    run8(OP_AND, 8'hCC, 8'hAA, "and_after_abort");

    for (int k = 0; k < 40; k++) begin
      run8(3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom), "rand8");
      idle8(int'($urandom_range(0, 2)));
    end

    run4(OP_XNOR, 4'hA, 4'hA, "w4_xnor_a_a");
    for (int k = 0; k < 12; k++)
      run4(3'($urandom_range(1, 7)), 4'($urandom), 4'($urandom), "rand4");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
